rvb_pcpi_cmp: RTL and testbench

// Downstream checker for a reference/mutated pair of rvb_pcpi instances sharing one issue port.

---
 rtl/rvb_pcpi_cmp.sv | 186 ++++++++++++++++++
 tb/tb_rvb_pcpi_cmp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rvb_pcpi_cmp.sv
// Downstream checker for a reference/mutated pair of PCPI coprocessors on a shared issue port.
// Captures each side's first response and reports a per-transaction verdict.
//
// state    | meaning
// S_IDLE   | no transaction outstanding; waits for pcpi_valid
// S_WAIT   | transaction issued; latching each side's first ready, aging, skew tracking
// S_REPORT | one-cycle verdict (done/pass/err_code valid)
module rvb_pcpi_cmp #(
   parameter int TIMEOUT  = 64,
   parameter int MAX_SKEW = 0,
   parameter int CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_pcpi_valid,
   input  logic [31:0]      i_pcpi_insn,
   input  logic             i_ref_pcpi_ready,
   input  logic             i_ref_pcpi_wr,
   input  logic [31:0]      i_ref_pcpi_rd,
   input  logic             i_mut_pcpi_ready,
   input  logic             i_mut_pcpi_wr,
   input  logic [31:0]      i_mut_pcpi_rd,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [4:0]       o_err_code,
   output logic [4:0]       o_err_sticky,
   output logic [31:0]      o_last_insn,
   output logic [CNT_W-1:0] o_txn_count,
   output logic [CNT_W-1:0] o_err_count
);

   // Age and skew never exceed TIMEOUT+1, so this width cannot overflow.
   localparam int AW = $clog2(TIMEOUT + 2);
   localparam logic [AW-1:0] TO_V = AW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPORT} state_t;

   state_t           r_state;
   logic [AW-1:0]    r_age;
   logic [AW-1:0]    r_skew_cnt;
   logic             r_skew_err;
   logic             r_spur;
   logic             r_ref_got;
   logic             r_mut_got;
   logic             r_ref_wr;
   logic             r_mut_wr;
   logic [31:0]      r_ref_rd;
   logic [31:0]      r_mut_rd;
   logic             r_done;
   logic             r_pass;
   logic [4:0]       r_err_code;
   logic [4:0]       r_err_sticky;
   logic [31:0]      r_last_insn;
   logic [CNT_W-1:0] r_txn_count;
   logic [CNT_W-1:0] r_err_count;

   logic             w_ref_new;
   logic             w_mut_new;
   logic             w_ref_got;
   logic             w_mut_got;
   logic             w_ref_wr;
   logic             w_mut_wr;
   logic [31:0]      w_ref_rd;
   logic [31:0]      w_mut_rd;
   logic [AW-1:0]    w_age;
   logic [AW-1:0]    w_skew_cnt;
   logic             w_skew_err;
   logic             w_spur;
   logic             w_both;
   logic             w_timeout;
   logic             w_finish;
   logic [4:0]       w_code;

   // The verdict uses this cycle's readies as well as earlier latches.
   always_comb begin
      w_ref_new  = i_ref_pcpi_ready & ~r_ref_got;
      w_mut_new  = i_mut_pcpi_ready & ~r_mut_got;
      w_ref_got  = r_ref_got | i_ref_pcpi_ready;
      w_mut_got  = r_mut_got | i_mut_pcpi_ready;
      w_ref_wr   = r_ref_got ? r_ref_wr : i_ref_pcpi_wr;
      w_mut_wr   = r_mut_got ? r_mut_wr : i_mut_pcpi_wr;
      w_ref_rd   = r_ref_got ? r_ref_rd : i_ref_pcpi_rd;
      w_mut_rd   = r_mut_got ? r_mut_rd : i_mut_pcpi_rd;
      w_age      = r_age + AW'(1);
      w_skew_cnt = r_skew_cnt + AW'(r_ref_got ^ r_mut_got);
      w_skew_err = r_skew_err | (int'(w_skew_cnt) > MAX_SKEW);
      w_spur     = r_spur | i_pcpi_valid
                 | (i_ref_pcpi_ready & r_ref_got)
                 | (i_mut_pcpi_ready & r_mut_got);
      w_both     = w_ref_got & w_mut_got;
      w_timeout  = (w_age == TO_V) & ~w_both;
      w_finish   = (r_ref_got & r_mut_got) | w_timeout;
      w_code     = {w_spur,
                    w_timeout,
                    w_skew_err,
                    w_both & w_ref_wr & w_mut_wr & (w_ref_rd != w_mut_rd),
                    w_both & (w_ref_wr != w_mut_wr)};
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_age        <= '0;
         r_skew_cnt   <= '0;
         r_skew_err   <= 1'b0;
         r_spur       <= 1'b0;
         r_ref_got    <= 1'b0;
         r_mut_got    <= 1'b0;
         r_ref_wr     <= 1'b0;
         r_mut_wr     <= 1'b0;
         r_ref_rd     <= '0;
         r_mut_rd     <= '0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_code   <= '0;
         r_err_sticky <= '0;
         r_last_insn  <= '0;
         r_txn_count  <= '0;
         r_err_count  <= '0;
      end else begin
         r_done     <= 1'b0;
         r_pass     <= 1'b0;
         r_err_code <= '0;
         case (r_state)
            S_IDLE: begin
               if (i_pcpi_valid) begin
                  r_state     <= S_WAIT;
                  r_last_insn <= i_pcpi_insn;
                  r_age       <= '0;
                  r_skew_cnt  <= '0;
                  r_skew_err  <= 1'b0;
                  r_spur      <= 1'b0;
                  r_ref_got   <= 1'b0;
                  r_mut_got   <= 1'b0;
               end else if (i_ref_pcpi_ready | i_mut_pcpi_ready) begin
                  r_err_sticky[4] <= 1'b1;
               end
            end
            S_WAIT: begin
               r_age      <= w_age;
               r_skew_cnt <= w_skew_cnt;
               r_skew_err <= w_skew_err;
               r_spur     <= w_spur;
               if (w_ref_new) begin
                  r_ref_got <= 1'b1;
                  r_ref_wr  <= i_ref_pcpi_wr;
                  r_ref_rd  <= i_ref_pcpi_rd;
               end
               if (w_mut_new) begin
                  r_mut_got <= 1'b1;
                  r_mut_wr  <= i_mut_pcpi_wr;
                  r_mut_rd  <= i_mut_pcpi_rd;
               end
               if (w_finish) begin
                  r_state      <= S_REPORT;
                  r_done       <= 1'b1;
                  r_pass       <= ~|w_code;
                  r_err_code   <= w_code;
                  r_err_sticky <= r_err_sticky | w_code;
                  r_txn_count  <= r_txn_count + CNT_W'(1);
                  if (|w_code && !(&r_err_count))
                     r_err_count <= r_err_count + CNT_W'(1);
               end
            end
            S_REPORT: begin
               r_state <= S_IDLE;
               // Anything arriving while the verdict is out has no transaction to belong to.
               if (i_pcpi_valid | i_ref_pcpi_ready | i_mut_pcpi_ready)
                  r_err_sticky[4] <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_err_code   = r_err_code;
   assign o_err_sticky = r_err_sticky;
   assign o_last_insn  = r_last_insn;
   assign o_txn_count  = r_txn_count;
   assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_rvb_pcpi_cmp.sv
// Scoreboard bench for rvb_pcpi_cmp: three instances (MAX_SKEW 0/1, CNT_W 16/3) share stimulus;
// expected verdicts are queued at issue and popped by a monitor on each done pulse.
module tb_rvb_pcpi_cmp;

   localparam int T = 8;

   typedef struct packed {
      int          cyc;
      logic [31:0] insn;
      logic [4:0]  code;
      logic [4:0]  sticky;
      logic [15:0] txn;
      logic [15:0] errc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic        ref_ready, ref_wr, mut_ready, mut_wr;
   logic [31:0] ref_rd, mut_rd;

   logic [2:0]        busy_v, done_v, pass_v;
   logic [2:0][4:0]   code_v, sticky_v;
   logic [2:0][31:0]  insn_v;
   logic [2:0][15:0]  txn_v, errc_v;
   logic [2:0]        txn2, errc2;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   logic want_zero = 1'b0;
   logic end_req = 1'b0;
   logic busy_chk = 1'b0;

   exp_t q0[$], q1[$], q2[$];
   int          m_txn[3];
   int          m_err[3];
   logic [4:0]  m_sticky[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rvb_pcpi_cmp #(.TIMEOUT(T), .MAX_SKEW(0), .CNT_W(16)) dut0 (
      .i_clk(clk), .i_reset(reset), .i_pcpi_valid(pcpi_valid), .i_pcpi_insn(pcpi_insn),
      .i_ref_pcpi_ready(ref_ready), .i_ref_pcpi_wr(ref_wr), .i_ref_pcpi_rd(ref_rd),
      .i_mut_pcpi_ready(mut_ready), .i_mut_pcpi_wr(mut_wr), .i_mut_pcpi_rd(mut_rd),
      .o_busy(busy_v[0]), .o_done(done_v[0]), .o_pass(pass_v[0]), .o_err_code(code_v[0]),
      .o_err_sticky(sticky_v[0]), .o_last_insn(insn_v[0]), .o_txn_count(txn_v[0]),
      .o_err_count(errc_v[0]));

   rvb_pcpi_cmp #(.TIMEOUT(T), .MAX_SKEW(1), .CNT_W(16)) dut1 (
      .i_clk(clk), .i_reset(reset), .i_pcpi_valid(pcpi_valid), .i_pcpi_insn(pcpi_insn),
      .i_ref_pcpi_ready(ref_ready), .i_ref_pcpi_wr(ref_wr), .i_ref_pcpi_rd(ref_rd),
      .i_mut_pcpi_ready(mut_ready), .i_mut_pcpi_wr(mut_wr), .i_mut_pcpi_rd(mut_rd),
      .o_busy(busy_v[1]), .o_done(done_v[1]), .o_pass(pass_v[1]), .o_err_code(code_v[1]),
      .o_err_sticky(sticky_v[1]), .o_last_insn(insn_v[1]), .o_txn_count(txn_v[1]),
      .o_err_count(errc_v[1]));

   rvb_pcpi_cmp #(.TIMEOUT(T), .MAX_SKEW(0), .CNT_W(3)) dut2 (
      .i_clk(clk), .i_reset(reset), .i_pcpi_valid(pcpi_valid), .i_pcpi_insn(pcpi_insn),
      .i_ref_pcpi_ready(ref_ready), .i_ref_pcpi_wr(ref_wr), .i_ref_pcpi_rd(ref_rd),
      .i_mut_pcpi_ready(mut_ready), .i_mut_pcpi_wr(mut_wr), .i_mut_pcpi_rd(mut_rd),
      .o_busy(busy_v[2]), .o_done(done_v[2]), .o_pass(pass_v[2]), .o_err_code(code_v[2]),
      .o_err_sticky(sticky_v[2]), .o_last_insn(insn_v[2]), .o_txn_count(txn2),
      .o_err_count(errc2));

   assign txn_v[2]  = {13'b0, txn2};
   assign errc_v[2] = {13'b0, errc2};

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s dut%0d: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
      end
   endtask

   task automatic check_entry(input int k, input exp_t e);
      chk("done_cycle", k, 64'(cyc), 64'(e.cyc));
      chk("err_code", k, 64'(code_v[k]), 64'(e.code));
      chk("pass", k, 64'(pass_v[k]), 64'(e.code == 5'd0));
      chk("err_sticky", k, 64'(sticky_v[k]), 64'(e.sticky));
      chk("last_insn", k, 64'(insn_v[k]), 64'(e.insn));
      chk("txn_count", k, 64'(txn_v[k]), 64'(e.txn));
      chk("err_count", k, 64'(errc_v[k]), 64'(e.errc));
   endtask

   always @(negedge clk) begin
      if (done_v[0]) begin
         if (q0.size() > 0) check_entry(0, q0.pop_front());
         else chk("unexpected_done", 0, 64'd1, 64'd0);
      end
      if (done_v[1]) begin
         if (q1.size() > 0) check_entry(1, q1.pop_front());
         else chk("unexpected_done", 1, 64'd1, 64'd0);
      end
      if (done_v[2]) begin
         if (q2.size() > 0) check_entry(2, q2.pop_front());
         else chk("unexpected_done", 2, 64'd1, 64'd0);
      end
      if (busy_chk) chk("busy_after_report", 0, 64'(busy_v[0]), 64'd0);
      busy_chk <= done_v[0];
      if (want_zero) begin
         for (int k = 0; k < 3; k++) begin
            chk("rst_busy", k, 64'(busy_v[k]), 64'd0);
            chk("rst_done_pass_code", k, 64'({done_v[k], pass_v[k], code_v[k]}), 64'd0);
            chk("rst_sticky", k, 64'(sticky_v[k]), 64'd0);
            chk("rst_last_insn", k, 64'(insn_v[k]), 64'd0);
            chk("rst_counts", k, 64'({txn_v[k], errc_v[k]}), 64'd0);
         end
      end
      if (end_req)
         chk("verdicts_outstanding", 0, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
      if (cyc > 20000) begin
         $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
         $fatal(1, "watchdog");
      end
   end

   // dr/dm: cycle offset after issue of each side's ready (0 = never); r2: extra ref ready offset.
   task automatic do_txn(input logic [31:0] insn, input int dr, input int dm, input int r2,
                         input logic rwr, input logic [31:0] rrd,
                         input logic mwr, input logic [31:0] mrd);
      int   i0, off, skc, lo;
      logic okr, okm, both;
      exp_t e;
      i0 = cyc;
      pcpi_valid = 1'b1; pcpi_insn = insn;
      ref_wr = rwr; ref_rd = rrd; mut_wr = mwr; mut_rd = mrd;
      okr  = (dr != 0) && (dr <= T);
      okm  = (dm != 0) && (dm <= T);
      both = okr && okm;
      off  = both ? ((dr > dm ? dr : dm) + 2) : (T + 1);
      lo   = okr ? dr : dm;
      skc  = both ? (dr > dm ? dr - dm : dm - dr) : ((okr ^ okm) ? (T - lo) : 0);
      for (int k = 0; k < 3; k++) begin
         e.cyc  = i0 + off;
         e.insn = insn;
         e.code = {r2 != 0, !both, skc > (k == 1 ? 1 : 0),
                   both && rwr && mwr && (rrd != mrd), both && (rwr != mwr)};
         m_txn[k]++;
         if (e.code != 5'd0 && m_err[k] < (k == 2 ? 7 : 65535)) m_err[k]++;
         m_sticky[k] |= e.code;
         e.sticky = m_sticky[k];
         e.txn    = 16'(m_txn[k] % (k == 2 ? 8 : 65536));
         e.errc   = 16'(m_err[k]);
         if (k == 0) q0.push_back(e);
         else if (k == 1) q1.push_back(e);
         else q2.push_back(e);
      end
      for (int t = 1; t <= off; t++) begin
         @(posedge clk); #1;
         pcpi_valid = 1'b0;
         ref_ready  = (t == dr) || (t == r2);
         mut_ready  = (t == dm);
      end
      @(posedge clk); #1;
      ref_ready = 1'b0; mut_ready = 1'b0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_txn[k] = 0; m_err[k] = 0; m_sticky[k] = 5'd0;
      end
   endtask

   initial begin
      reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0;
      ref_ready = 1'b0; ref_wr = 1'b0; ref_rd = '0;
      mut_ready = 1'b0; mut_wr = 1'b0; mut_rd = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0; want_zero = 1'b1;
      @(posedge clk); #1 want_zero = 1'b0;

      do_txn(32'h20B55533, 3, 3, 0, 1'b1, 32'h1234, 1'b1, 32'h1234);   // match
      do_txn(32'h20B55533, 3, 3, 0, 1'b1, 32'h1234, 1'b1, 32'h1235);   // rd differs
      do_txn(32'h02A5C5B3, 3, 4, 0, 1'b1, 32'hCAFE, 1'b1, 32'hCAFE);   // 1-cycle skew
      do_txn(32'h00000013, 2, 0, 0, 1'b1, 32'h1,    1'b1, 32'h1);      // mut timeout
      do_txn(32'h00000033, 0, 0, 0, 1'b0, 32'h0,    1'b0, 32'h0);      // both timeout

      ref_ready = 1'b1;                                                 // stray ready in IDLE
      for (int k = 0; k < 3; k++) m_sticky[k] |= 5'b10000;
      @(posedge clk); #1 ref_ready = 1'b0;
      @(posedge clk); #1;
      do_txn(32'h40B50533, 1, 1, 0, 1'b1, 32'h55AA, 1'b1, 32'h55AA);

      do_txn(32'h12345678, 2, 2, 0, 1'b1, 32'h7,    1'b0, 32'h7);      // wr differs
      do_txn(32'h9ABCDEF0, 2, 2, 0, 1'b0, 32'h7,    1'b0, 32'h8);      // wr=0 ignores rd
      do_txn(32'h0F0F0F0F, 2, 2, 3, 1'b1, 32'h9,    1'b1, 32'h9);      // repeated ref ready
      do_txn(32'hFFFFFFFF, T, T, 0, 1'b1, 32'hAB,   1'b1, 32'hAB);     // readies at age TIMEOUT

      for (int n = 0; n < 9; n++)
         do_txn(32'h100 + 32'(n), 1, 1, 0, 1'b1, 32'(n), 1'b1, 32'(n + 1));

      pcpi_valid = 1'b1; pcpi_insn = 32'hDEADBEEF;                     // abandoned by reset
      @(posedge clk); #1 pcpi_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0; want_zero = 1'b1;
      model_reset();
      @(posedge clk); #1 want_zero = 1'b0;
      do_txn(32'h00C58533, 2, 2, 0, 1'b1, 32'h42, 1'b1, 32'h42);

      repeat (3) @(posedge clk);
      #1 end_req = 1'b1;
      @(posedge clk); #1 end_req = 1'b0;
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
